// File: rtl/test_pattern_pkg.sv
// ----------------------------------------------------------------------------
// test_pattern_pkg
// Shared constants for the test-pattern framebuffer responder:
//   - RGB565 colours: 12-entry rainbow palette (red .. raspberry),
//     WHITE, BLACK and ERR_COLOR (magenta, returned for out-of-sequence reads)
//   - pattern mode encodings
// ----------------------------------------------------------------------------
package test_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_HBARS   = 2'd1,
        MODE_VBARS   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    localparam logic [15:0] WHITE     = 16'hFFFF;
    localparam logic [15:0] BLACK     = 16'h0000;
    localparam logic [15:0] ERR_COLOR = 16'hF81F;

    localparam int unsigned PALETTE_LEN = 12;

    // Index 0 is red, index 11 is raspberry.
    localparam logic [PALETTE_LEN-1:0][15:0] PALETTE = {
        16'hF80F,   // 11 raspberry
        16'hF81F,   // 10 magenta
        16'h801F,   //  9 violet
        16'h001F,   //  8 blue
        16'h041F,   //  7 azure
        16'h07FF,   //  6 cyan
        16'h07EF,   //  5 spring green
        16'h07E0,   //  4 green
        16'h87E0,   //  3 chartreuse
        16'hFFE0,   //  2 yellow
        16'hFBE0,   //  1 orange
        16'hF800    //  0 red
    };

    function automatic logic [15:0] palette_color(input logic [3:0] idx);
        logic [15:0] c;
        c = PALETTE[0];
        for (int unsigned i = 0; i < PALETTE_LEN; i++) begin
            if (idx == 4'(i)) c = PALETTE[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// ----------------------------------------------------------------------------
// rd_latency_pipe
// DEPTH-deep valid+data shift register with synchronous clear.
// Data of a stage only loads when the preceding stage is valid, so the output
// data holds its value between valid pulses.
// Ports:
//   clk, clear          clock, synchronous clear (empties pipe, zeroes data)
//   in_valid, in_data   entry of the pipe
//   out_valid, out_data exit of the pipe, DEPTH cycles later
// ----------------------------------------------------------------------------
module rd_latency_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     dat [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/test_pattern_mem.sv
// ----------------------------------------------------------------------------
// test_pattern_mem
// Framebuffer-read responder standing in for pixel memory. Answers byte reads
// with RGB565 test-pattern bytes (solid, horizontal bars, vertical bars,
// checkerboard) after READ_LATENCY cycles.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   mem_req       read request, one byte per cycle
//   mem_addr      byte address (pixel = addr>>1, addr[0]=0 high byte)
//   mode          pattern select, latched at addr 0
//   solid_color   colour for solid mode, latched at addr 0
//   frame_done    pulse advancing the bar scroll offset
//   mem_out       read data, held between mem_ready pulses
//   mem_ready     single-cycle data-valid pulse
//   seq_err       sticky flag for a non-sequential address
// Build option: define TEST_PATTERN_SCROLL_EN to enable per-frame bar
// scrolling driven by frame_done; otherwise frame_done is ignored.
// ----------------------------------------------------------------------------
module test_pattern_mem
    import test_pattern_pkg::*;
#(
    parameter int unsigned FB_X         = 80,
    parameter int unsigned FB_Y         = 60,
    parameter int unsigned NUM_BARS     = 12,
    parameter int unsigned CHECK_SHIFT  = 3,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mode,
    input  logic [15:0]       solid_color,
    input  logic              frame_done,
    output logic [7:0]        mem_out,
    output logic              mem_ready,
    output logic              seq_err
);

    localparam int unsigned XW    = $clog2(FB_X + 1);
    localparam int unsigned YW    = $clog2(FB_Y + 1);
    localparam int unsigned BAR_H = FB_Y / NUM_BARS;
    localparam int unsigned BAR_W = FB_X / NUM_BARS;

    // Cursor state
    logic [XW-1:0]     x_q, col_q;
    logic [YW-1:0]     y_q, row_q;
    logic [3:0]        hbar_q, vbar_q;
    logic              byte_q;
    logic [ADDR_W-1:0] next_addr_q;
    mode_e             mode_q;
    logic [15:0]       color_q;

    // Effective cursor for this request (origin when addr is 0)
    logic              is_origin, is_seq;
    logic [XW-1:0]     cx, ccol, nx, ncol;
    logic [YW-1:0]     cy, crow, ny, nrow;
    logic [3:0]        chbar, cvbar, nhbar, nvbar;
    logic              cbyte, nbyte;
    mode_e             eff_mode;
    logic [15:0]       eff_color;
    logic [3:0]        eff_scroll;

    logic [3:0]        bar;
    logic [4:0]        bar_sum;
    logic [XW-1:0]     xs;
    logic [YW-1:0]     ys;
    logic [15:0]       pix;
    logic [7:0]        rd_byte;

    assign is_origin = (mem_addr == '0);
    assign is_seq    = (mem_addr == next_addr_q);

`ifdef TEST_PATTERN_SCROLL_EN
    logic [3:0] scroll, scroll_q, scroll_next;

    always_comb begin
        scroll_next = scroll;
        if (frame_done) scroll_next = (scroll == 4'(NUM_BARS - 1)) ? '0 : scroll + 4'd1;
    end

    // A frame_done coinciding with addr 0 is already visible to the new frame.
    assign eff_scroll = is_origin ? scroll_next : scroll_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scroll   <= '0;
            scroll_q <= '0;
        end else begin
            scroll <= scroll_next;
            if (mem_req && is_origin) scroll_q <= scroll_next;
        end
    end
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign eff_scroll        = '0;
`endif

    always_comb begin
        cx        = is_origin ? '0 : x_q;
        cy        = is_origin ? '0 : y_q;
        ccol      = is_origin ? '0 : col_q;
        crow      = is_origin ? '0 : row_q;
        chbar     = is_origin ? '0 : hbar_q;
        cvbar     = is_origin ? '0 : vbar_q;
        cbyte     = is_origin ? 1'b0 : byte_q;
        eff_mode  = is_origin ? mode_e'(mode) : mode_q;
        eff_color = is_origin ? solid_color : color_q;
    end

    // Incremental cursor advance; bar counters saturate on the last bar so
    // leftover rows/columns keep the final colour.
    always_comb begin
        nx    = cx;
        ny    = cy;
        ncol  = ccol;
        nrow  = crow;
        nhbar = chbar;
        nvbar = cvbar;
        nbyte = ~cbyte;
        if (cbyte) begin
            if (cx == XW'(FB_X - 1)) begin
                nx    = '0;
                ncol  = '0;
                nvbar = '0;
                if (cy == YW'(FB_Y - 1)) begin
                    ny    = '0;
                    nrow  = '0;
                    nhbar = '0;
                end else begin
                    ny = cy + YW'(1);
                    if (crow == YW'(BAR_H - 1) && chbar != 4'(NUM_BARS - 1)) begin
                        nrow  = '0;
                        nhbar = chbar + 4'd1;
                    end else begin
                        nrow = crow + YW'(1);
                    end
                end
            end else begin
                nx = cx + XW'(1);
                if (ccol == XW'(BAR_W - 1) && cvbar != 4'(NUM_BARS - 1)) begin
                    ncol  = '0;
                    nvbar = cvbar + 4'd1;
                end else begin
                    ncol = ccol + XW'(1);
                end
            end
        end
    end

    // Pixel colour at the accept cycle
    always_comb begin
        bar     = (eff_mode == MODE_VBARS) ? cvbar : chbar;
        bar_sum = {1'b0, bar} + {1'b0, eff_scroll};
        if (bar_sum >= 5'(NUM_BARS)) bar_sum = bar_sum - 5'(NUM_BARS);
        xs = cx >> CHECK_SHIFT;
        ys = cy >> CHECK_SHIFT;
        case (eff_mode)
            MODE_SOLID:   pix = eff_color;
            MODE_CHECKER: pix = (xs[0] ^ ys[0]) ? WHITE : BLACK;
            default:      pix = palette_color(bar_sum[3:0]);
        endcase
        if (is_origin || is_seq) rd_byte = cbyte ? pix[7:0] : pix[15:8];
        else                     rd_byte = mem_addr[0] ? ERR_COLOR[7:0] : ERR_COLOR[15:8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hbar_q      <= '0;
            vbar_q      <= '0;
            byte_q      <= 1'b0;
            next_addr_q <= '0;
            mode_q      <= MODE_HBARS;
            color_q     <= '0;
            seq_err     <= 1'b0;
        end else if (mem_req) begin
            if (is_origin || is_seq) begin
                x_q         <= nx;
                y_q         <= ny;
                col_q       <= ncol;
                row_q       <= nrow;
                hbar_q      <= nhbar;
                vbar_q      <= nvbar;
                byte_q      <= nbyte;
                next_addr_q <= mem_addr + ADDR_W'(1);
                if (is_origin) begin
                    mode_q  <= eff_mode;
                    color_q <= solid_color;
                end
            end else begin
                seq_err <= 1'b1;
            end
        end
    end

    rd_latency_pipe #(
        .DEPTH (READ_LATENCY),
        .W     (8)
    ) u_pipe (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (mem_req),
        .in_data   (rd_byte),
        .out_valid (mem_ready),
        .out_data  (mem_out)
    );

endmodule

// File: tb/tb_test_pattern_mem.sv
// ----------------------------------------------------------------------------
// tb_test_pattern_mem
// Self-checking bench for test_pattern_mem (READ_LATENCY = 4). A reference
// model derives each expected byte from the address with division/modulo and
// checks data, response cycle, hold behaviour and seq_err every cycle.
// ----------------------------------------------------------------------------
module tb_test_pattern_mem;

    localparam int FB_X = 80;
    localparam int FB_Y = 60;
    localparam int NB   = 12;
    localparam int CS   = 3;
    localparam int LAT  = 4;
    localparam int NPIX = FB_X * FB_Y;

`ifdef TEST_PATTERN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [1:0]  mode = 2'd1;
    logic [15:0] solid_color = '0;
    logic        frame_done = 1'b0;
    logic [7:0]  mem_out;
    logic        mem_ready;
    logic        seq_err;

    test_pattern_mem #(
        .FB_X         (FB_X),
        .FB_Y         (FB_Y),
        .NUM_BARS     (NB),
        .CHECK_SHIFT  (CS),
        .READ_LATENCY (LAT),
        .ADDR_W       (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mode        (mode),
        .solid_color (solid_color),
        .frame_done  (frame_done),
        .mem_out     (mem_out),
        .mem_ready   (mem_ready),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          ready_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_pal(input int i);
        logic [15:0] t [12] = '{16'hF800, 16'hFBE0, 16'hFFE0, 16'h87E0, 16'h07E0, 16'h07EF,
                                16'h07FF, 16'h041F, 16'h001F, 16'h801F, 16'hF81F, 16'hF80F};
        return t[i];
    endfunction

    function automatic logic [15:0] ref_pixel(input int p, input int m, input logic [15:0] c, input int s);
        int x, y, b;
        x = p % FB_X;
        y = p / FB_X;
        case (m)
            0: return c;
            1: begin b = y / (FB_Y / NB); if (b > NB - 1) b = NB - 1; return ref_pal((b + s) % NB); end
            2: begin b = x / (FB_X / NB); if (b > NB - 1) b = NB - 1; return ref_pal((b + s) % NB); end
            default: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    typedef struct {
        logic [7:0]  d;
        int unsigned due;
        logic [31:0] addr;
    } resp_t;

    resp_t       q[$];
    resp_t       e;
    logic [31:0] m_next = '0;
    int          m_mode = 1;
    logic [15:0] m_color = '0;
    int          m_scroll = 0;
    int          m_scroll_q = 0;
    logic        m_err = 1'b0;
    logic [7:0]  m_last = '0;
    logic [15:0] px;
    int          s_new;
    logic [7:0]  captured [19200];

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (mem_ready === 1'b1) begin
                ready_cnt++;
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_ready cyc=%0d mem_out=%h required no response", cyc, mem_out);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checks++;
                    assert (mem_out === e.d) else begin
                        errors++;
                        $error("FAIL data addr=%0d got=%h exp=%h", e.addr, mem_out, e.d);
                    end
                    checks++;
                    assert (cyc === e.due) else begin
                        errors++;
                        $error("FAIL latency addr=%0d got_cyc=%0d exp_cyc=%0d", e.addr, cyc, e.due);
                    end
                    if (e.addr < 19200) captured[e.addr] = mem_out;
                    m_last = e.d;
                end
            end else begin
                checks++;
                assert (mem_ready === 1'b0 && mem_out === m_last) else begin
                    errors++;
                    $error("FAIL idle_hold ready=%b out=%h exp_ready=0 exp_out=%h", mem_ready, mem_out, m_last);
                end
                checks++;
                assert (q.size() == 0 || q[0].due > cyc) else begin
                    errors++;
                    $error("FAIL missing_ready addr=%0d got=none exp_cyc=%0d", q[0].addr, q[0].due);
                end
            end
            checks++;
            assert (seq_err === m_err) else begin
                errors++;
                $error("FAIL seq_err cyc=%0d got=%b exp=%b", cyc, seq_err, m_err);
            end

            if (reset) begin
                q.delete();
                m_next = '0; m_mode = 1; m_color = '0; m_scroll = 0; m_scroll_q = 0;
                m_err = 1'b0; m_last = '0;
            end else begin
                s_new = m_scroll;
                if (SCROLL && frame_done) s_new = (m_scroll + 1) % NB;
                m_scroll = s_new;
                if (mem_req) begin
                    if (mem_addr == 0) begin
                        m_mode = int'(mode); m_color = solid_color; m_scroll_q = s_new;
                    end
                    if (mem_addr == 0 || mem_addr == m_next) begin
                        px  = ref_pixel(int'((mem_addr >> 1) % NPIX), m_mode, m_color, m_scroll_q);
                        e.d = mem_addr[0] ? px[7:0] : px[15:8];
                        m_next = mem_addr + 1;
                    end else begin
                        e.d = mem_addr[0] ? 8'h1F : 8'hF8;
                        m_err = 1'b1;
                    end
                    e.due  = cyc + LAT;
                    e.addr = mem_addr;
                    q.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        mem_req  = 1'b1;
        mem_addr = 32'(a);
        tick();
        mem_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        idle(LAT + 2);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain pending=%0d exp=0", q.size());
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    int r0, len, a;

    initial begin
        // reset state
        idle(3);
        chk8("reset_mem_out", mem_out, 8'h00);
        chk8("reset_ready", {7'd0, mem_ready}, 8'h00);
        chk8("reset_seq_err", {7'd0, seq_err}, 8'h00);
        reset = 1'b0;

        // full frame, horizontal bars
        mode = 2'd1;
        for (int i = 0; i < 2 * NPIX; i++) rd(i);
        drain();
        chk8("hbar_b0", captured[0], 8'hF8);
        chk8("hbar_b1", captured[1], 8'h00);
        chk8("hbar_800", captured[800], 8'hFB);
        chk8("hbar_801", captured[801], 8'hE0);
        chk8("hbar_last_hi", captured[9598], 8'hF8);
        chk8("hbar_last_lo", captured[9599], 8'h0F);
        chk8("hbar_seq_err", {7'd0, seq_err}, 8'h00);

        // checkerboard
        mode = 2'd3;
        for (int i = 0; i < 1300; i++) rd(i);
        drain();
        chk8("chk_7_0_hi", captured[14], 8'h00);
        chk8("chk_7_0_lo", captured[15], 8'h00);
        chk8("chk_8_0_hi", captured[16], 8'hFF);
        chk8("chk_8_0_lo", captured[17], 8'hFF);
        chk8("chk_8_8_hi", captured[1296], 8'h00);
        chk8("chk_8_8_lo", captured[1297], 8'h00);

        // 10 back-to-back requests
        r0 = ready_cnt;
        for (int i = 0; i < 10; i++) rd(i);
        drain();
        chk8("b2b_count", 8'(ready_cnt - r0), 8'd10);

        // randomized frames with gaps, frame_done and mid-frame mode changes
        for (int f = 0; f < 12; f++) begin
            mode = 2'($urandom_range(0, 3));
            solid_color = 16'($urandom);
            len = int'($urandom_range(20, 600));
            a = 0;
            while (a < len) begin
                frame_done = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 19) == 0) begin
                    mode = 2'($urandom);
                    solid_color = 16'($urandom);
                end
                if ($urandom_range(0, 9) == 0) idle(1);
                else begin rd(a); a++; end
                frame_done = 1'b0;
            end
        end
        drain();

        // address jump
        do_reset();
        mode = 2'd1;
        rd(0); rd(1); rd(2);
        chk8("jump_err_before", {7'd0, seq_err}, 8'h00);
        rd(500);
        chk8("jump_err_after", {7'd0, seq_err}, 8'h01);
        rd(3);
        drain();
        chk8("jump_err_byte", captured[500], 8'hF8);
        chk8("jump_continue", captured[3], 8'h00);

        // scroll: frame_done then addr 0
        do_reset();
        mode = 2'd1;
        frame_done = 1'b1;
        idle(1);
        frame_done = 1'b0;
        rd(0);
        drain();
        chk8("scroll_sep", captured[0], SCROLL ? 8'hFB : 8'hF8);

        // scroll: frame_done with addr 0 in the same cycle
        do_reset();
        frame_done = 1'b1;
        rd(0);
        frame_done = 1'b0;
        drain();
        chk8("scroll_same", captured[0], SCROLL ? 8'hFB : 8'hF8);

        // mid-frame mode change is ignored
        do_reset();
        mode = 2'd1;
        for (int i = 0; i < 10; i++) rd(i);
        mode = 2'd0;
        solid_color = 16'h1234;
        for (int i = 10; i < 1602; i++) rd(i);
        drain();
        chk8("midframe_hi", captured[1600], 8'hFF);
        chk8("midframe_lo", captured[1601], 8'hE0);

        // reset with requests in flight
        rd(0); rd(1); rd(2);
        r0 = ready_cnt;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(10);
        chk8("inflight_ready", 8'(ready_cnt - r0), 8'd0);
        chk8("inflight_out", mem_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_pattern_mem.md
# test_pattern_mem

Parametrised framebuffer-read responder that stands in for pixel memory behind `ili9341_spi_controller`. It answers the controller's byte-wide `mem_req`/`mem_addr` reads with RGB565 pixel bytes. It generates selectable test patterns (solid, horizontal bars, vertical bars, checkerboard), with configurable read latency and optional per-frame bar scrolling. The block instantiates in `top` in place of the inline memory mock.

## Interface
Parameters:
- `FB_X`, 80: framebuffer width in pixels (downscaled display width).
- `FB_Y`, 60: framebuffer height in pixels.
- `NUM_BARS`, 12: colour bars per frame, 1..12.
- `CHECK_SHIFT`, 3: checkerboard square size is 2^CHECK_SHIFT pixels.
- `READ_LATENCY`, 1: cycles from request to `mem_ready`, 1..8.
- `ADDR_W`, 32: address width.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `mem_req`  in  1: read request, one byte per cycle while high.
- `mem_addr`  in  ADDR_W: byte address. Pixel index is `addr>>1`. `addr[0]`=0 selects the high byte; `addr[0]`=1 selects the low byte.
- `mode`  in  2: pattern select. 0 = solid, 1 = horizontal bars, 2 = vertical bars, 3 = checkerboard.
- `solid_color`  in  16: RGB565 colour for mode 0.
- `frame_done`  in  1: single-cycle pulse that advances the scroll offset.
- `mem_out`  out  8: read data.
- `mem_ready`  out  1: single-cycle pulse; `mem_out` is valid in that cycle.
- `seq_err`  out  1: sticky flag, set by a non-sequential address.

## Operation
- Cursor (x, y, byte_sel, bar_idx, row_in_bar, col_in_bar) is tracked incrementally. The block has no divider.
- Request acceptance (every cycle `mem_req`=1):
  - addr == 0: cursor resets to origin. `mode` and `solid_color` are latched into `mode_q` and `color_q`. The frame starts.
  - addr == expected (last accepted + 1): cursor advances by one byte. Pixel position advances after the low byte. x wraps at FB_X and increments y. After byte 2·FB_X·FB_Y−1, the cursor wraps to origin.
  - Any other addr: `seq_err` is set. The response is `ERR_COLOR` byte `addr[0]`. The cursor is unchanged.
- Colour per pixel:
  - Solid: `color_q`.
  - H bars: bar = y / (FB_Y/NUM_BARS). Rows beyond NUM_BARS·(FB_Y/NUM_BARS) use bar NUM_BARS−1.
  - V bars: the same rule applied to x with FB_X.
  - Checker: `((x>>CHECK_SHIFT) ^ (y>>CHECK_SHIFT)) & 1` selects WHITE, otherwise BLACK.
  - Bar colour: `PALETTE[(bar + scroll_q) mod NUM_BARS]`.
- Mode changes mid-frame are ignored until the next addr-0 request.
- `seq_err` clears only on reset.

## Timing
- Reset values:
  - `mem_out`=0, `mem_ready`=0, `seq_err`=0.
  - Cursor at origin, `scroll`=0, `scroll_q`=0.
  - `mode_q`=1, `color_q`=0.
  - Latency pipeline empty.
- Latency: a request accepted at cycle T gives `mem_ready`=1 with data at T+READ_LATENCY.
- `mem_out` holds its value until the next `mem_ready`.
- Back-to-back requests are fully pipelined, one response per cycle, in order.
- The colour is computed at the accept cycle. The pipeline carries only byte data.
- `seq_err` asserts at T+1.
- `frame_done` alone: `scroll` increments mod NUM_BARS at the next edge.
- `frame_done` together with an addr-0 request in the same cycle: the new frame latches the incremented offset.
- `scroll_q` is latched only at addr 0, so there is no tearing.
- Reset mid-frame: in-flight responses are discarded, so no `mem_ready` occurs after the reset edge. The cursor returns to origin.

## Configuration
- `TEST_PATTERN_SCROLL_EN` defined: `frame_done` advances `scroll` as above.
- Not defined:
  - `frame_done` is ignored and `scroll_q` is constant 0.
  - The bar colour is `PALETTE[bar]`.
  - The scroll registers are not synthesised.

## Structure
- Shared package `test_pattern_pkg`:
  - RGB565 constants (12-entry rainbow `PALETTE`: red through raspberry).
  - `WHITE`, `BLACK`, `ERR_COLOR` (magenta).
  - Mode encodings.
- One sub-module `rd_latency_pipe`: a READ_LATENCY-deep valid+data shift register with synchronous clear.

## Test plan
- Reset, mode=1, FB 80×60, 12 bars, sequential reads 0..9599:
  - byte 0 = 0xF8, byte 1 = 0x00 (red).
  - addr 800 → 0xFB, 0xE0 (orange).
  - Last row is raspberry: 0xF8, 0x0F.
  - `seq_err`=0.
- mode=3, CHECK_SHIFT=3:
  - pixel (7,0) is BLACK 0x0000.
  - pixel (8,0) is WHITE 0xFFFF.
  - pixel (8,8) is BLACK.
- READ_LATENCY=4, 10 back-to-back requests → 10 `mem_ready` pulses, at cycles T+4..T+13, in order.
- Addr jump 0,1,2,500 → `seq_err`=1 one cycle later. Addr 500 returns 0xF8 (magenta high byte). The next addr 3 continues the correct pattern.
- With `TEST_PATTERN_SCROLL_EN`, mode=1: `frame_done` pulse, then frame restart at addr 0 → byte 0 = 0xFB (orange). Same cycle `frame_done` + addr 0 → same result.
- Mid-frame mode change 1→0 leaves the frame striped. Reset asserted with 3 requests in flight → no `mem_ready` afterwards and `mem_out`=0.
